// File: rtl/pipelined_logic_unit.sv
// rtl/pipelined_logic_unit.sv - two-stage valid/ready bitwise logic unit with reduction flags (optional accumulator: PLU_ACC_EN)
module pipelined_logic_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             acc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             all_ones,
    output logic             any_one
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] c_next;
    logic             s2_load;
    logic             in_fire;

    // S2 takes S1 whenever its own slot is empty or being drained this cycle,
    // so a full pipe still accepts one input per cycle while out_ready is high.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    // Bitwise operation selected by op; purely width-preserving.
    always_comb begin
        r_next = '0;
        case (op)
            2'b00:   r_next = A & B;
            2'b01:   r_next = A | B;
            2'b10:   r_next = A ^ B;
            default: r_next = ~(A | B);
        endcase
    end

`ifdef PLU_ACC_EN
    logic             s1_acc;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_base;

    // A clear coinciding with an accumulating load makes that load see all-ones.
    assign acc_base = acc_clr ? {WIDTH{1'b1}} : acc_q;
    assign c_next   = s1_acc ? (s1_r & acc_base) : s1_r;

    // S1 copy of the accumulate request, travelling alongside s1_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_acc <= 1'b0;
        end else if (in_fire) begin
            s1_acc <= acc;
        end
    end

    // Accumulator: an accumulating load wins over a bare clear (it already folded the clear in).
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= {WIDTH{1'b1}};
        end else if (s2_load && s1_acc) begin
            acc_q <= c_next;
        end else if (acc_clr) begin
            acc_q <= {WIDTH{1'b1}};
        end
    end
`else
    logic unused_acc_inputs;

    assign unused_acc_inputs = acc ^ acc_clr;
    assign c_next            = s1_r;
`endif

    // Stage 1: capture the operation result on an input transfer, empty when handed to S2.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_r     <= r_next;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result and flags; held stable while stalled by out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            C         <= '0;
            all_ones  <= 1'b0;
            any_one   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            C         <= c_next;
            all_ones  <= &c_next;
            any_one   <= |c_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
